// File: rtl/div16sx8u_seq_pkg.sv
// Shared DCTQ divider definitions: default widths, FSM encoding and saturation values.
// Optional rounding is enabled in the top level by defining DIV16_ROUND_EN.
package div16sx8u_seq_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Divide-by-zero results for non-negative and negative dividends
  localparam logic [DEF_DIVIDEND_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DEF_DIVIDEND_W-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/div16sx8u_seq_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// then subtract the divisor if it fits.
module div_restore_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   pr_in,
  input  logic                 mag_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_out,
  output logic                 qbit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  // When the subtraction succeeds the result is below the divisor, so the low bits suffice
  always_comb begin
    shifted = {pr_in, mag_msb};
    qbit    = (shifted >= {2'b00, divisor});
    diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
    pr_out  = qbit ? diff : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/div16sx8u_seq.sv
// Sequential signed-by-unsigned radix-2 restoring divider with valid/ready handshakes.
// Define DIV16_ROUND_EN to round the quotient half away from zero.
module div16sx8u_seq
  import div16sx8u_seq_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W:0]    remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                state_reg, state_next;
  logic [DIVIDEND_W-1:0] mag_reg;
  logic [DIVISOR_W:0]    pr_reg;
  logic [DIVISOR_W-1:0]  div_reg;
  logic                  neg_reg;
  logic                  dz_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DIVIDEND_W-1:0] quotient_reg;
  logic [DIVISOR_W:0]    remainder_reg;
  logic                  dz_out_reg;

  logic [DIVISOR_W:0]    step_pr;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] q_mag;
  logic [DIVIDEND_W-1:0] q_signed;
  logic [DIVISOR_W:0]    r_signed;

  div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .pr_in   (pr_reg),
    .mag_msb (mag_reg[DIVIDEND_W-1]),
    .divisor (div_reg),
    .pr_out  (step_pr),
    .qbit    (step_q)
  );

  // Quotient bits shift into the vacated low end of the magnitude register
  always_comb begin
`ifdef DIV16_ROUND_EN
    q_mag = mag_reg + DIVIDEND_W'({pr_reg, 1'b0} >= {2'b00, div_reg});
`else
    q_mag = mag_reg;
`endif
    q_signed = neg_reg ? -q_mag : q_mag;
    r_signed = neg_reg ? -pr_reg : pr_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = ITER;
      ITER: if (count_reg == '0) state_next = SIGN;
      SIGN: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mag_reg       <= '0;
      pr_reg        <= '0;
      div_reg       <= '0;
      neg_reg       <= 1'b0;
      dz_reg        <= 1'b0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_out_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          neg_reg   <= dividend[DIVIDEND_W-1];
          mag_reg   <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
          div_reg   <= divisor;
          dz_reg    <= (divisor == '0);
          pr_reg    <= '0;
          count_reg <= CNT_W'(DIVIDEND_W - 1);
        end
        ITER: begin
          pr_reg  <= step_pr;
          mag_reg <= {mag_reg[DIVIDEND_W-2:0], step_q};
          if (count_reg != '0) count_reg <= count_reg - 1'b1;
        end
        SIGN: begin
          if (dz_reg) begin
            quotient_reg  <= neg_reg ? SAT_NEG : SAT_POS;
            remainder_reg <= '0;
            dz_out_reg    <= 1'b1;
          end else begin
            quotient_reg  <= q_signed;
            remainder_reg <= r_signed;
            dz_out_reg    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dz_out_reg;

endmodule

// File: tb/tb_div16sx8u_seq.sv
// Self-checking bench for div16sx8u_seq: directed cases plus random operands against
// an arithmetic reference model (honours DIV16_ROUND_EN when defined).
module tb_div16sx8u_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [8:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q;
  logic [8:0]  exp_r;
  logic        exp_dz;

  div16sx8u_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division truncates toward zero, % takes the dividend's sign
  task automatic model(input logic [15:0] a, input logic [7:0] b);
    int ai, bi, q, r, ar;
    ai = int'($signed(a));
    bi = int'(b);
    if (bi == 0) begin
      exp_q  = (ai < 0) ? 16'h8000 : 16'h7FFF;
      exp_r  = '0;
      exp_dz = 1'b1;
    end else begin
      q  = ai / bi;
      r  = ai % bi;
      ar = (r < 0) ? -r : r;
`ifdef DIV16_ROUND_EN
      if (2 * ar >= bi) q = (ai < 0) ? q - 1 : q + 1;
`endif
      exp_q  = q[15:0];
      exp_r  = r[8:0];
      exp_dz = 1'b0;
    end
  endtask

  // Issue one operation, measure latency, compare, optionally consume the result
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit consume);
    int lat;
    model(a, b);
    @(negedge clk);
    check("in_ready_before", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("op %0d / %0d : q=0x%04h r=0x%03h dz=%0b lat=%0d (exp q=0x%04h r=0x%03h dz=%0b)",
             $signed(a), b, quotient, remainder, div_by_zero, lat, exp_q, exp_r, exp_dz);
    check("latency", 32'(lat), 32'd18);
    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_consume", 32'(out_valid), 32'd0);
      check("in_ready_after_consume", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    out_ready = 1'b0;

    // Directed cases, including the extreme and divide-by-zero corners
    run_op(16'd1000, 8'd7, 1'b1);
    run_op(-16'sd1000, 8'd7, 1'b1);
    run_op(16'h8000, 8'd1, 1'b1);
    check("min_div_one_q", 32'(quotient), 32'h8000);
    run_op(16'd500, 8'd0, 1'b1);
    check("pos_dz_q", 32'(quotient), 32'h7FFF);
    run_op(-16'sd5, 8'd0, 1'b1);
    check("neg_dz_q", 32'(quotient), 32'h8000);
    run_op(16'd100, 8'd8, 1'b1);
    run_op(-16'sd100, 8'd8, 1'b1);
    run_op(16'd99, 8'd8, 1'b1);
    run_op(16'h7FFF, 8'd255, 1'b1);
    run_op(16'd0, 8'd3, 1'b1);

    // Back-pressure: result held while new requests are ignored
    run_op(16'd1234, 8'd11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'(exp_q));
      check("bp_remainder", 32'(remainder), 32'(exp_r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    run_op(16'd32385, 8'd255, 1'b1);
    check("bp_next_q", 32'(quotient), 32'd127);

    // Reset in the middle of the iteration phase drops the operation
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_quotient", 32'(quotient), 32'd0);
    run_op(16'd100, 8'd3, 1'b1);
    check("after_rst_q", 32'(quotient), 32'd33);
    check("after_rst_r", 32'(remainder), 32'd1);

    // Random operands, with divide-by-zero mixed in
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
